coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
- Front-end stage directly upstream of the vending machine FSM.
- Synchronises and debounces the raw nickel/dime sensor lines, then emits one single-cycle coin code per physical coin on the 2-bit coin bus the vending FSM consumes.
- Rejects ambiguous inputs: both sensors active, or coins arriving while disabled.
- Flags sensor jams as sticky until cleared.

Parameters:
- DEBOUNCE, 4, consecutive synchronised-high samples required to accept a coin (>=2).
- JAM_CYCLES, 64, cycles a sensor may stay high after acceptance/reject before jam is declared (> DEBOUNCE).
- CNT_W, 8, width of the accepted-coin counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- nickel_in  in  1  raw nickel sensor, asynchronous, active-high.
- dime_in  in  1  raw dime sensor, asynchronous, active-high.
- enable  in  1  1 = accept coins; 0 = coins are rejected.
- jam_clr  in  1  clears jam (level).
- coin  out  2  0 none, 1 nickel, 2 dime, 3 never driven; registered.
- reject  out  1  one-cycle pulse per rejected coin event; registered.
- jam  out  1  sticky jam flag; registered.
- accepted  out  CNT_W  count of coins emitted, wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, async): coin=0, reject=0, jam=0, accepted=0, state IDLE, counter 0, synchroniser flops 0.
- Inputs pass through a 2-flop synchroniser; the FSM sees only the synchronised values sn and sd.
- IDLE:
  - sn xor sd → DEBOUNCE; latch type (nickel/dime); cnt=1.
  - sn and sd both high → reject pulse; HELD with cnt=0.
  - Otherwise stay.
- DEBOUNCE:
  - Latched sensor low → IDLE, no output (glitch filtered).
  - Other sensor high → reject pulse; HELD with cnt=0.
  - Otherwise cnt++. When the sample making cnt==DEBOUNCE arrives: if enable=1, coin=type for exactly one cycle and accepted++; if enable=0, reject pulse instead. Then HELD with cnt=0.
- HELD:
  - sn=sd=0 → IDLE.
  - Otherwise cnt++; on reaching JAM_CYCLES → JAM.
- JAM:
  - jam=1.
  - Leaves to IDLE (jam=0) only on a cycle with jam_clr=1 and sn=sd=0.
  - No coin or reject is emitted while in JAM.
- enable is sampled only on the acceptance cycle; toggling it mid-debounce has no other effect.
- Latency: raw input high before edge 1 and held → coin high in the cycle after edge DEBOUNCE+2 (sync edges 1–2, FSM samples at edges 3..DEBOUNCE+2). With DEBOUNCE=4, coin is high after edge 6 only.
- At most one coin or reject pulse per physical insertion; coin and reject are never high in the same cycle.
- coin returns to 0 the cycle after a pulse, even if the sensor is still held.
- cnt width: $clog2(JAM_CYCLES+1); saturates at JAM_CYCLES.
- accepted wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-debounce or in JAM: immediate return to reset values; a sensor still held after reset release is treated as a new insertion.

Decomposition:
- Shared package vending_pkg:
  - coin encoding constants COIN_NONE=2'd0, COIN_NICKEL=2'd1, COIN_DIME=2'd2. The vending FSM imports the same constants.
  - acceptor state enum {IDLE, DEBOUNCE, HELD, JAM}.
- One sub-module: coin_sync, a 2-bit two-flop synchroniser with async active-low reset. It is instantiated once.

Test Plan:
- Clean nickel (DEBOUNCE=4): nickel_in=1 for 20 cycles, enable=1 → coin=1 for exactly the cycle after edge 6, accepted=1, reject never high.
- Glitch: dime_in high for 3 cycles then low → coin stays 0, reject stays 0, accepted=0, FSM back in IDLE.
- Simultaneous: nickel_in and dime_in raised on the same cycle for 10 cycles → one reject pulse; coin=0; next clean dime then gives coin=2.
- Disabled: enable=0, clean dime held 10 cycles → one reject pulse at the acceptance cycle; coin=0; accepted unchanged.
- Jam: nickel_in held 100 cycles (JAM_CYCLES=64) → one coin=1 pulse, then jam=1. jam_clr=1 while nickel_in is still high → jam stays 1. After release with jam_clr=1 → jam=0 and the next insertion is accepted.
- Reset mid-operation: assert reset during DEBOUNCE → all outputs 0 asynchronously. Release with the sensor still high → coin pulse occurs DEBOUNCE+2 edges after release.

Source files
------------

// File: rtl/vending_pkg.sv
// Definitions shared by the coin acceptor and the vending FSM downstream:
// the 2-bit coin bus encoding and the acceptor state set.
package vending_pkg;

   localparam logic [1:0] COIN_NONE   = 2'd0;
   localparam logic [1:0] COIN_NICKEL = 2'd1;
   localparam logic [1:0] COIN_DIME   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_HELD,
      ST_JAM
   } acc_state_e;

   function automatic logic [1:0] coin_code(input logic is_dime);
      return is_dime ? COIN_DIME : COIN_NICKEL;
   endfunction

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchroniser for the two raw coin sensor lines.
module coin_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] async_i,
   output logic [1:0] sync_o
);

   logic [1:0] meta_q;
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: synchronises and debounces the nickel/dime sensors and emits
// one single-cycle coin code (or reject pulse) per physical coin; flags jams.
module coin_acceptor
   import vending_pkg::*;
#(
   parameter int DEBOUNCE   = 4,
   parameter int JAM_CYCLES = 64,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             nickel_in,
   input  logic             dime_in,
   input  logic             enable,
   input  logic             jam_clr,
   output logic [1:0]       coin,
   output logic             reject,
   output logic             jam,
   output logic [CNT_W-1:0] accepted
);

   localparam int CW = $clog2(JAM_CYCLES + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE);
   localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES);

   logic [1:0] sens_sync;
   logic       sn;
   logic       sd;

   acc_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dime_q, dime_d;
   logic [1:0]       coin_q, coin_d;
   logic             reject_q, reject_d;
   logic             jam_q, jam_d;
   logic [CNT_W-1:0] acc_q, acc_d;

   logic          latched;
   logic          other;
   logic [CW-1:0] cnt_inc;

   coin_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i ({dime_in, nickel_in}),
      .sync_o  (sens_sync)
   );

   assign sn = sens_sync[0];
   assign sd = sens_sync[1];

   // Sensor that started the debounce versus the one that must stay quiet.
   assign latched = dime_q ? sd : sn;
   assign other   = dime_q ? sn : sd;
   assign cnt_inc = (cnt_q == JAM_LAST) ? cnt_q : cnt_q + CW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         dime_q   <= 1'b0;
         coin_q   <= COIN_NONE;
         reject_q <= 1'b0;
         jam_q    <= 1'b0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dime_q   <= dime_d;
         coin_q   <= coin_d;
         reject_q <= reject_d;
         jam_q    <= jam_d;
         acc_q    <= acc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dime_d   = dime_q;
      coin_d   = COIN_NONE;
      reject_d = 1'b0;
      jam_d    = jam_q;
      acc_d    = acc_q;

      case (state_q)
         ST_IDLE: begin
            if (sn && sd) begin
               reject_d = 1'b1;
               state_d  = ST_HELD;
               cnt_d    = '0;
            end else if (sn ^ sd) begin
               state_d = ST_DEBOUNCE;
               dime_d  = sd;
               cnt_d   = CW'(1);
            end
         end

         ST_DEBOUNCE: begin
            if (!latched) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (other) begin
               reject_d = 1'b1;
               state_d  = ST_HELD;
               cnt_d    = '0;
            end else if (cnt_inc == DEB_LAST) begin
               // enable matters only on this acceptance sample
               if (enable) begin
                  coin_d = coin_code(dime_q);
                  acc_d  = acc_q + CNT_W'(1);
               end else begin
                  reject_d = 1'b1;
               end
               state_d = ST_HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_HELD: begin
            if (!sn && !sd) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == JAM_LAST) begin
                  state_d = ST_JAM;
                  jam_d   = 1'b1;
               end
            end
         end

         ST_JAM: begin
            jam_d = 1'b1;
            if (jam_clr && !sn && !sd) begin
               state_d = ST_IDLE;
               jam_d   = 1'b0;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign coin     = coin_q;
   assign reject   = reject_q;
   assign jam      = jam_q;
   assign accepted = acc_q;

endmodule
